// File: rtl/accel_pkg.sv
// Shared constants and types for the operand skew buffer.
//   DEF_SIZE / DEF_DATA_W : default tile dimension and element width
//   state_e               : LOAD (filling banks) / FEED (streaming skewed tile)
//   skew_cnt_w()          : width of the skew step counter t
package accel_pkg;

  localparam int unsigned DEF_SIZE   = 8;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    FEED = 1'b1
  } state_e;

  // t runs 0 .. 2*size-2 and never wraps
  function automatic int unsigned skew_cnt_w(input int unsigned size);
    return $clog2(2 * size - 1);
  endfunction

endpackage

// File: rtl/operand_skew_buffer_if.sv
// Write/feed bus of the operand skew buffer.
//   buf_data_in, read_a, read_b : bank write word and strobes (from control_register)
//   feed_ready                  : systolic array accepts the current skew step
//   feed_valid, a_out, b_out,
//   feed_first, feed_last       : skewed operand step towards the array edges
// master = upstream/array side, slave = buffer side.
interface operand_skew_buffer_if
  import accel_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_SIZE,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [SIZE*DATA_W-1:0] buf_data_in;
  logic                   read_a;
  logic                   read_b;
  logic                   feed_ready;
  logic                   feed_valid;
  logic [SIZE*DATA_W-1:0] a_out;
  logic [SIZE*DATA_W-1:0] b_out;
  logic                   feed_first;
  logic                   feed_last;

  modport master (
    output buf_data_in, read_a, read_b, feed_ready,
    input  feed_valid, a_out, b_out, feed_first, feed_last
  );

  modport slave (
    input  buf_data_in, read_a, read_b, feed_ready,
    output feed_valid, a_out, b_out, feed_first, feed_last
  );

endinterface

// File: rtl/skew_lane_mux.sv
// One skew lane: selects element (t - lane_i) of a bank row, or 0 when that
// index falls outside the row.
//   row_i  : SIZE packed elements, element k at [k*DATA_W +: DATA_W]
//   t_i    : current skew step
//   lane_i : lane index (tied to a constant by the instantiating module)
//   elem_o : selected element or 0
module skew_lane_mux
  import accel_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_SIZE,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TW     = skew_cnt_w(SIZE)
) (
  input  logic [SIZE*DATA_W-1:0] row_i,
  input  logic [TW-1:0]          t_i,
  input  logic [TW-1:0]          lane_i,
  output logic [DATA_W-1:0]      elem_o
);

  logic [TW-1:0] diff;

  // Only index when t >= lane; the loop bound enforces t - lane < SIZE
  always_comb begin
    elem_o = '0;
    diff   = t_i - lane_i;
    if (t_i >= lane_i) begin
      for (int k = 0; k < SIZE; k++) begin
        if (diff == TW'(k)) elem_o = row_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/operand_skew_buffer.sv
// Operand skew buffer: loads a SIZE x SIZE tile of A (rows) and B (columns)
// from control_register, then streams both with diagonal skew to the
// systolic array under valid/ready flow control.
//   clk, rst   : clock, synchronous active-high reset
//   err_clear  : clears sticky wr_err
//   bus        : write strobes/data in, skewed feed out (slave modport)
//   tile_done  : one-cycle pulse after the last step handshake
//   a_full     : A bank holds SIZE rows
//   b_full     : B bank holds SIZE columns
//   wr_err     : sticky, a write strobe was dropped
// Build option: B_TRANSPOSE_EN -- read_b words are rows of B and the B bank is
// read transposed; undefined, read_b words are columns of B.
module operand_skew_buffer
  import accel_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_SIZE,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_clear,
  operand_skew_buffer_if.slave bus,
  output logic                 tile_done,
  output logic                 a_full,
  output logic                 b_full,
  output logic                 wr_err
);

  localparam int unsigned TW = skew_cnt_w(SIZE);
  localparam int unsigned CW = $clog2(SIZE + 1);
  localparam int unsigned IW = $clog2(SIZE);
  localparam int unsigned WW = SIZE * DATA_W;
  localparam logic [TW-1:0] T_LAST   = TW'(2 * SIZE - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE);

  state_e        state_q, state_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [TW-1:0] t_q, t_d;
  logic          a_full_q, a_full_d, b_full_q, b_full_d;
  logic          wr_err_q, wr_err_d, tile_done_q, tile_done_d;
  logic [WW-1:0] a_bank_q [SIZE];
  logic [WW-1:0] b_bank_q [SIZE];
  logic [WW-1:0] a_lanes, b_lanes;
  logic          a_we, b_we, err_evt, feed_hs, last_hs;

  // Write qualification: A wins a simultaneous strobe, nothing lands in FEED
  always_comb begin
    a_we    = (state_q == LOAD) && bus.read_a && (a_cnt_q != CNT_FULL);
    b_we    = (state_q == LOAD) && bus.read_b && !bus.read_a && (b_cnt_q != CNT_FULL);
    err_evt = (bus.read_a && !a_we) || (bus.read_b && !b_we);
    feed_hs = (state_q == FEED) && bus.feed_ready;
    last_hs = feed_hs && (t_q == T_LAST);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (a_full_q && b_full_q) state_d = FEED;
      FEED: if (last_hs)              state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // FSM outputs; lanes are gated so LOAD presents all zeros
  always_comb begin
    bus.feed_valid = 1'b0;
    bus.feed_first = 1'b0;
    bus.feed_last  = 1'b0;
    bus.a_out      = '0;
    bus.b_out      = '0;
    if (state_q == FEED) begin
      bus.feed_valid = 1'b1;
      bus.feed_first = (t_q == '0);
      bus.feed_last  = (t_q == T_LAST);
      bus.a_out      = a_lanes;
      bus.b_out      = b_lanes;
    end
  end

  // Counter / flag next state; full flags lag the counters by one cycle and
  // are cleared with them on the last handshake so LOAD cannot re-enter FEED
  always_comb begin
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    t_d         = t_q;
    a_full_d    = (a_cnt_q == CNT_FULL);
    b_full_d    = (b_cnt_q == CNT_FULL);
    tile_done_d = last_hs;
    wr_err_d    = wr_err_q;
    if (a_we) a_cnt_d = a_cnt_q + CW'(1);
    if (b_we) b_cnt_d = b_cnt_q + CW'(1);
    if (feed_hs) t_d = t_q + TW'(1);
    if (last_hs) begin
      a_cnt_d  = '0;
      b_cnt_d  = '0;
      t_d      = '0;
      a_full_d = 1'b0;
      b_full_d = 1'b0;
    end
    if (err_clear) wr_err_d = 1'b0;
    if (err_evt)   wr_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      t_q         <= '0;
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      tile_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      t_q         <= t_d;
      a_full_q    <= a_full_d;
      b_full_q    <= b_full_d;
      tile_done_q <= tile_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Bank storage, contents undefined after reset
  always_ff @(posedge clk) begin
    if (a_we) a_bank_q[a_cnt_q[IW-1:0]] <= bus.buf_data_in;
    if (b_we) b_bank_q[b_cnt_q[IW-1:0]] <= bus.buf_data_in;
  end

  // Per-lane skew selection; B lane j consumes column j of B
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [WW-1:0] b_col;
`ifdef B_TRANSPOSE_EN
    // Bank holds rows of B: gather column i from element i of every row
    always_comb begin
      b_col = '0;
      for (int r = 0; r < SIZE; r++) b_col[r*DATA_W +: DATA_W] = b_bank_q[r][i*DATA_W +: DATA_W];
    end
`else
    assign b_col = b_bank_q[i];
`endif
    skew_lane_mux #(.SIZE(SIZE), .DATA_W(DATA_W), .TW(TW)) u_a_mux (
      .row_i  (a_bank_q[i]),
      .t_i    (t_q),
      .lane_i (TW'(i)),
      .elem_o (a_lanes[i*DATA_W +: DATA_W])
    );
    skew_lane_mux #(.SIZE(SIZE), .DATA_W(DATA_W), .TW(TW)) u_b_mux (
      .row_i  (b_col),
      .t_i    (t_q),
      .lane_i (TW'(i)),
      .elem_o (b_lanes[i*DATA_W +: DATA_W])
    );
  end

  assign tile_done = tile_done_q;
  assign a_full    = a_full_q;
  assign b_full    = b_full_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_operand_skew_buffer.sv
// Directed bench for operand_skew_buffer: basic tile, backpressure, write
// errors, interleaved loading and reset during FEED.
module tb_operand_skew_buffer;
  import accel_pkg::*;

  localparam int unsigned SIZE   = DEF_SIZE;
  localparam int unsigned DATA_W = DEF_DATA_W;
  localparam int unsigned WW     = SIZE * DATA_W;
  localparam int          NSTEP  = 2 * SIZE - 1;

  typedef struct {
    bit          ready;
    int          step;
    logic [WW-1:0] exp_a;
    logic [WW-1:0] exp_b;
    bit          exp_first;
    bit          exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic err_clear;
  logic tile_done, a_full, b_full, wr_err;

  operand_skew_buffer_if #(.SIZE(SIZE), .DATA_W(DATA_W)) bus ();

  operand_skew_buffer #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .err_clear (err_clear),
    .bus       (bus),
    .tile_done (tile_done),
    .a_full    (a_full),
    .b_full    (b_full),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  vec_t tbl [2][64];
  int   tbl_len [2];
  int   n_vec = 0;
  int   n_err = 0;
  logic [WW-1:0] garbage;

  // Expected skew step: lane i carries element (t-i) of A row / B column i
  function automatic logic [WW-1:0] model_lanes(input bit is_b, input int t);
    logic [WW-1:0] w;
    int d;
    w = '0;
    for (int i = 0; i < SIZE; i++) begin
      d = t - i;
      if (d >= 0 && d < SIZE) w[i*DATA_W +: DATA_W] = DATA_W'((is_b ? 256 : 0) + 16 * i + d);
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] word_a(input int i);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < SIZE; k++) w[k*DATA_W +: DATA_W] = DATA_W'(16 * i + k);
    return w;
  endfunction

  function automatic logic [WW-1:0] word_b(input int j);
    logic [WW-1:0] w;
    w = '0;
`ifdef B_TRANSPOSE_EN
    // j is a row index r; element c = 0x100 + 16*c + r
    for (int c = 0; c < SIZE; c++) w[c*DATA_W +: DATA_W] = DATA_W'(256 + 16 * c + j);
`else
    for (int k = 0; k < SIZE; k++) w[k*DATA_W +: DATA_W] = DATA_W'(256 + 16 * j + k);
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic write_a(input logic [WW-1:0] w);
    bus.read_a      = 1'b1;
    bus.buf_data_in = w;
    tick();
    bus.read_a      = 1'b0;
  endtask

  task automatic write_b(input logic [WW-1:0] w);
    bus.read_b      = 1'b1;
    bus.buf_data_in = w;
    tick();
    bus.read_b      = 1'b0;
  endtask

  task automatic load_tile();
    for (int i = 0; i < SIZE; i++) write_a(word_a(i));
    for (int j = 0; j < SIZE; j++) write_b(word_b(j));
  endtask

  // Called right after the last bank write: full at +1, valid at +2
  task automatic expect_start();
    chk("no valid right after last write", WW'({bus.feed_valid, b_full}), WW'(2'b00));
    tick();
    chk("full flags, still not valid", WW'({a_full, b_full, bus.feed_valid}), WW'(3'b110));
    tick();
    chk("valid two cycles after last write", WW'({bus.feed_valid, bus.feed_first}), WW'(2'b11));
  endtask

  // Apply table rows; stop early when step reaches stop_step, optionally
  // inject a read_a strobe (must be dropped) on row inject_k
  task automatic run_table(input int which, input int stop_step, input int inject_k);
    vec_t v;
    for (int k = 0; k < tbl_len[which]; k++) begin
      v = tbl[which][k];
      if (v.step == stop_step) return;
      bus.feed_ready = v.ready;
      chk($sformatf("a_out t=%0d", v.step), bus.a_out, v.exp_a);
      chk($sformatf("b_out t=%0d", v.step), bus.b_out, v.exp_b);
      chk($sformatf("valid/first/last t=%0d", v.step),
          WW'({bus.feed_valid, bus.feed_first, bus.feed_last}),
          WW'({1'b1, v.exp_first, v.exp_last}));
      if (v.step == 3) begin
        chk("t=3 a lane2", WW'(bus.a_out[2*DATA_W +: DATA_W]), WW'(32'h21));
        chk("t=3 b lane1", WW'(bus.b_out[1*DATA_W +: DATA_W]), WW'(32'h112));
      end
      if (v.step == 14) begin
        chk("t=14 a lanes", WW'(bus.a_out), WW'({32'h77, 224'h0}));
        chk("t=14 b lanes", WW'(bus.b_out), WW'({32'h177, 224'h0}));
      end
      if (k == inject_k) begin
        bus.read_a      = 1'b1;
        bus.buf_data_in = garbage;
      end
      tick();
      bus.read_a = 1'b0;
    end
    bus.feed_ready = 1'b0;
    chk("after last step valid=0 tile_done=1", WW'({bus.feed_valid, tile_done, a_full, b_full}), WW'(4'b0100));
    tick();
    chk("tile_done single pulse", WW'({bus.feed_valid, tile_done}), WW'(2'b00));
  endtask

  initial begin
    int s;
    garbage = {8{32'hDEAD_BEEF}};

    // Table 0: feed_ready held high, one step per cycle
    for (int k = 0; k < NSTEP; k++) begin
      tbl[0][k].ready     = 1'b1;
      tbl[0][k].step      = k;
      tbl[0][k].exp_a     = model_lanes(1'b0, k);
      tbl[0][k].exp_b     = model_lanes(1'b1, k);
      tbl[0][k].exp_first = (k == 0);
      tbl[0][k].exp_last  = (k == NSTEP - 1);
    end
    tbl_len[0] = NSTEP;

    // Table 1: feed_ready 1,0,0 repeating; step only advances on handshake
    s = 0;
    tbl_len[1] = 0;
    for (int k = 0; s < NSTEP; k++) begin
      tbl[1][k].ready     = ((k % 3) == 0);
      tbl[1][k].step      = s;
      tbl[1][k].exp_a     = model_lanes(1'b0, s);
      tbl[1][k].exp_b     = model_lanes(1'b1, s);
      tbl[1][k].exp_first = (s == 0);
      tbl[1][k].exp_last  = (s == NSTEP - 1);
      if ((k % 3) == 0) s++;
      tbl_len[1] = k + 1;
    end

    rst             = 1'b1;
    err_clear       = 1'b0;
    bus.read_a      = 1'b0;
    bus.read_b      = 1'b0;
    bus.feed_ready  = 1'b0;
    bus.buf_data_in = '0;
    tick();
    tick();
    chk("reset flags", WW'({bus.feed_valid, bus.feed_first, bus.feed_last, tile_done, a_full, b_full, wr_err}), WW'(0));
    chk("reset a_out", bus.a_out, '0);
    chk("reset b_out", bus.b_out, '0);
    rst = 1'b0;

    // Basic tile
    load_tile();
    expect_start();
    run_table(0, -1, -1);

    // Backpressure
    load_tile();
    expect_start();
    run_table(1, -1, -1);

    // Write errors
    for (int i = 0; i < SIZE - 1; i++) write_a(word_a(i));
    bus.read_a      = 1'b1;
    bus.read_b      = 1'b1;
    bus.buf_data_in = word_a(SIZE - 1);
    tick();
    bus.read_a = 1'b0;
    bus.read_b = 1'b0;
    chk("simultaneous strobes set wr_err", WW'(wr_err), WW'(1));
    tick();
    chk("simultaneous: only A filled", WW'({a_full, b_full}), WW'(2'b10));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_clear clears wr_err", WW'(wr_err), WW'(0));
    write_a(garbage);
    chk("ninth read_a sets wr_err", WW'(wr_err), WW'(1));
    err_clear = 1'b1;
    write_a(garbage);
    err_clear = 1'b0;
    chk("set beats clear", WW'(wr_err), WW'(1));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wr_err cleared again", WW'(wr_err), WW'(0));
    for (int j = 0; j < SIZE; j++) write_b(word_b(j));
    expect_start();
    run_table(1, -1, 1);
    chk("read_a in FEED sets wr_err", WW'(wr_err), WW'(1));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Interleaved writes with gaps
    for (int i = 0; i < SIZE; i++) begin
      write_a(word_a(i));
      tick();
      write_b(word_b(i));
      if (i < SIZE - 1) chk($sformatf("no feed while interleaving %0d", i), WW'(bus.feed_valid), WW'(0));
    end
    expect_start();
    run_table(0, -1, -1);

    // Reset mid-FEED at t=5
    load_tile();
    expect_start();
    run_table(0, 5, -1);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus.feed_ready = 1'b0;
    chk("mid-feed reset flags", WW'({bus.feed_valid, a_full, b_full, tile_done, wr_err}), WW'(0));
    tick();
    chk("no tile_done after abort", WW'({bus.feed_valid, tile_done}), WW'(0));
    load_tile();
    expect_start();
    run_table(0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_skew_buffer.md
Name: operand_skew_buffer

Overview:
- Sits directly downstream of control_register in the 1C102 accelerator.
- Captures the SIZE-element words that control_register presents on buf_data_in, qualified by read_a / read_b, into an A bank (rows) and a B bank (columns).
- Once a full SIZE x SIZE tile of each operand is held, streams them to the systolic array edges with diagonal skew, under valid/ready flow control.

Parameters:
- SIZE, 8, systolic array dimension; rows/columns per tile.
- DATA_W, 32, element width; SIZE*DATA_W = 256 matches buf_data_in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- buf_data_in  in  SIZE*DATA_W  write word; element e at bits [e*DATA_W +: DATA_W].
- read_a  in  1  write strobe: buf_data_in is the next row of A.
- read_b  in  1  write strobe: buf_data_in is the next column of B.
- err_clear  in  1  clears sticky wr_err.
- feed_ready  in  1  array accepts the current skew step.
- feed_valid  out  1  a_out/b_out hold a valid skew step.
- a_out  out  SIZE*DATA_W  lane i feeds array row i.
- b_out  out  SIZE*DATA_W  lane j feeds array column j.
- feed_first  out  1  current step is t=0.
- feed_last  out  1  current step is t=2*SIZE-2.
- tile_done  out  1  one-cycle pulse after the last step handshake.
- a_full  out  1  A bank holds SIZE rows.
- b_full  out  1  B bank holds SIZE columns.
- wr_err  out  1  sticky: a write was dropped.

Behaviour:
- Reset (rst=1 sampled at posedge):
  - State=LOAD; a_cnt=b_cnt=t=0; all outputs 0.
  - Bank contents are don't-care.
  - Reset mid-FEED aborts the tile; no tile_done.
- LOAD state:
  - read_a with a_cnt<SIZE: write A[a_cnt]; a_cnt++.
  - read_b with b_cnt<SIZE: write B[b_cnt]; b_cnt++.
  - a_full = (a_cnt==SIZE); b_full = (b_cnt==SIZE); both registered from the counters.
- Simultaneous read_a and read_b: A write wins; B write dropped; wr_err set.
- Strobe to a full bank, or any strobe in FEED: dropped; wr_err set.
- wr_err is cleared only by err_clear or rst. If err_clear and a new error occur in the same cycle, set wins.
- LOAD -> FEED: on the cycle after both banks are full; t=0.
- FEED state:
  - feed_valid=1.
  - a_out lane i = A[i][t-i] when 0 <= t-i < SIZE, else 0.
  - b_out lane j = B[j][t-j] when 0 <= t-j < SIZE, else 0.
  - Outputs are combinational from the registered banks and t; stable while feed_valid & !feed_ready.
  - Handshake = feed_valid & feed_ready: t++.
  - feed_first = (t==0); feed_last = (t==2*SIZE-2).
- Handshake on the last step:
  - State -> LOAD; a_cnt=b_cnt=t=0.
  - tile_done=1 on the following cycle only.
  - Writes are accepted from the first LOAD cycle.
- Latency: last bank write at cycle N -> full flags at N+1 -> feed_valid at N+2. With feed_ready held high, exactly 2*SIZE-1 consecutive valid cycles.
- t width: clog2(2*SIZE-1); it never wraps, because the last step always returns to LOAD.

Optional Feature:
- Macro B_TRANSPOSE_EN.
- Defined: read_b words are rows of B. The bank stores them as written, and b_out lane j = B_row[t-j][j], i.e. a transposed read. Window conditions are unchanged.
- Undefined: read_b words are columns, used as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Package accel_pkg:
  - SIZE and DATA_W defaults.
  - State enum {LOAD, FEED}.
  - Skew-count width function clog2(2*SIZE-1).
- Sub-module skew_lane_mux (one instance per lane): takes a bank row, t and lane index; outputs the element or 0.
- The same sub-module serves both banks.

Test Plan:
- Basic tile: write A[i][k]=16*i+k and B[j][k]=0x100+16*j+k via 8 read_a then 8 read_b, with feed_ready=1.
  - Required: feed_valid 2 cycles after the last write.
  - t=0: a_out lane0=0x00, lanes1-7=0.
  - t=3: a lane2=0x21, b lane1=0x112.
  - t=14: only lane7 nonzero (a=0x77, b=0x177); feed_last=1.
  - 15 handshakes total; tile_done pulses once.
- Backpressure: same tile, feed_ready toggling 1,0,0,1 ...
  - Required: outputs and t hold while ready=0.
  - Step count stays 15; no step is skipped or repeated.
- Write errors:
  - Ninth read_a -> A unchanged, wr_err=1.
  - read_a and read_b in the same cycle -> only a_cnt increments, wr_err=1.
  - read_a during FEED -> dropped.
  - err_clear -> wr_err=0.
- Interleaved writes: A and B strobes alternating with gaps -> FEED starts only after both are full; data matches the basic tile.
- Reset mid-FEED: rst at t=5 -> next cycle feed_valid=0, flags 0, no tile_done; a new full load then produces a correct tile.
- B_TRANSPOSE_EN build: write B as rows B[r][c]=0x100+16*c+r -> b_out identical to the basic tile.
